output_port_demux: RTL and testbench

- Inverse of the pipeline's round-robin input stage: takes the single datapath stream at the end of the user pipeline and steers each packet to one or more of NUM_QUEUES output interfaces.
- The destination comes from the one-hot port bitmap in the IOQ module header word.
- Sits between the last pipeline stage and the per-port output queues.
- Supports multicast: one copy per set bit, written in lockstep. Zero-destination packets are dropped.

---
 rtl/output_port_demux_pkg.sv | 20 ++
 rtl/fallthrough_small_fifo.sv | 72 +++++++
 rtl/output_port_demux.sv | 144 ++++++++++++++
 tb/tb_output_port_demux.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_demux_pkg.sv
// Shared definitions for the output port demux: IOQ header layout, FSM encoding
// and the end-of-packet framing rule.
package output_port_demux_pkg;

    localparam int IOQ_STAGE_NUM_DEFAULT = 'hFF;
    localparam int DST_POS_DEFAULT       = 16;
    localparam int DST_FIELD_WIDTH       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        DROP   = 2'd2
    } demux_state_e;

    // A packet ends on the first non-zero ctrl word that follows a payload word.
    function automatic logic is_eop(input logic cur_ctrl_nz, input logic prev_ctrl_nz);
        return cur_ctrl_nz && !prev_ctrl_nz;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on dout while
// empty is low, and rd_en retires it. Writes into a full FIFO are discarded.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2,
    parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] NF_CNT    = CW'(NEARLY_FULL);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [WIDTH-1:0]          mem_d [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      full;
    logic                      do_write;
    logic                      do_read;

    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= NF_CNT);
    assign do_write    = wr_en && !full;
    assign do_read     = rd_en && !empty;
    assign dout        = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + MAX_DEPTH_BITS'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/output_port_demux.sv
// Steers each packet of the pipeline stream to the output ports selected by the
// one-hot bitmap in its IOQ header; multicast copies advance in lockstep.
module output_port_demux
    import output_port_demux_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int IOQ_STAGE_NUM   = IOQ_STAGE_NUM_DEFAULT,
    parameter int DST_POS         = DST_POS_DEFAULT,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [NUM_QUEUES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_QUEUES*CTRL_WIDTH-1:0] out_ctrl,
    output logic [NUM_QUEUES-1:0]            out_wr,
    input  logic [NUM_QUEUES-1:0]            out_rdy,
    output logic                             pkt_dropped
);

    localparam int FIFO_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam int FIFO_DEPTH = 2**FIFO_DEPTH_BITS;
    localparam int DST_BITS   = (NUM_QUEUES < DST_FIELD_WIDTH) ? NUM_QUEUES : DST_FIELD_WIDTH;
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_nearly_full;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [NUM_QUEUES-1:0] head_dst;
    logic                  head_eop;
    logic                  ports_go;
    logic                  wr_pop;
    logic                  drop_pop;

    demux_state_e                state_q, state_d;
    logic [NUM_QUEUES-1:0]       dst_mask_q, dst_mask_d;
    logic [CTRL_WIDTH-1:0]       prev_ctrl_q, prev_ctrl_d;
    logic [NUM_QUEUES-1:0]       out_wr_q, out_wr_d;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                        pkt_dropped_q, pkt_dropped_d;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS),
        .NEARLY_FULL    (FIFO_DEPTH - 1)
    ) u_in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign in_rdy = !fifo_nearly_full;
    assign {head_ctrl, head_data} = fifo_dout;
    assign head_dst = NUM_QUEUES'(head_data[DST_POS +: DST_BITS]);
    assign head_eop = is_eop(head_ctrl != '0, prev_ctrl_q != '0);

    // A word moves only when every selected port can take it, so copies never diverge.
    assign ports_go = !fifo_empty && ((out_rdy & dst_mask_q) == dst_mask_q);
    assign wr_pop   = (state_q == WR_PKT) && ports_go;
    assign drop_pop = (state_q == DROP) && !fifo_empty;
    assign fifo_rd  = wr_pop || drop_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dst_mask_q    <= '0;
            prev_ctrl_q   <= CTRL_WIDTH'(1);
            out_wr_q      <= '0;
            out_data_q    <= '0;
            out_ctrl_q    <= '0;
            pkt_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dst_mask_q    <= dst_mask_d;
            prev_ctrl_q   <= prev_ctrl_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_ctrl_q    <= out_ctrl_d;
            pkt_dropped_q <= pkt_dropped_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dst_mask_d  = dst_mask_q;
        prev_ctrl_d = prev_ctrl_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_ctrl == IOQ_CTRL) begin
                        dst_mask_d = head_dst;
                        state_d    = (head_dst != '0) ? WR_PKT : DROP;
                    end else begin
                        dst_mask_d = '0;
                        state_d    = DROP;
                    end
                end
            end
            WR_PKT, DROP: begin
                if (fifo_rd) begin
                    if (head_eop) begin
                        prev_ctrl_d = CTRL_WIDTH'(1);
                        state_d     = IDLE;
                    end else begin
                        prev_ctrl_d = head_ctrl;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unselected lanes carry the same word; only out_wr qualifies it.
    always_comb begin
        out_wr_d      = wr_pop ? dst_mask_q : '0;
        out_data_d    = out_data_q;
        out_ctrl_d    = out_ctrl_q;
        pkt_dropped_d = drop_pop && head_eop;
        if (wr_pop) begin
            out_data_d = {NUM_QUEUES{head_data}};
            out_ctrl_d = {NUM_QUEUES{head_ctrl}};
        end
    end

    assign out_wr      = out_wr_q;
    assign out_data    = out_data_q;
    assign out_ctrl    = out_ctrl_q;
    assign pkt_dropped = pkt_dropped_q;

endmodule

// File: tb/tb_output_port_demux.sv
// Directed bench for output_port_demux: expected words are queued as packets are
// driven and compared as the ports write them.
module tb_output_port_demux;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int NQ   = 8;
    localparam int CHKW = 512;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DW-1:0]    in_data;
    logic [CW-1:0]    in_ctrl;
    logic             in_wr;
    logic             in_rdy;
    logic [NQ*DW-1:0] out_data;
    logic [NQ*CW-1:0] out_ctrl;
    logic [NQ-1:0]    out_wr;
    logic [NQ-1:0]    out_rdy;
    logic             pkt_dropped;

    typedef struct {
        logic [NQ-1:0] mask;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] pkt_data[$];
    logic [CW-1:0] pkt_ctrl[$];
    logic [NQ-1:0] pkt_mask;

    int checks = 0;
    int failures = 0;
    int drop_count = 0;
    int wr_events = 0;
    int cyc = 0;
    int first_wr = -1;
    int last_wr = -1;
    int drops_before;

    output_port_demux #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .NUM_QUEUES (NQ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .out_wr      (out_wr),
        .out_rdy     (out_rdy),
        .pkt_dropped (pkt_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [CHKW-1:0] obs, input logic [CHKW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every write pops one scoreboard entry shared by all selected ports.
    always @(negedge clk) begin
        cyc++;
        if (pkt_dropped === 1'b1) drop_count++;
        if (out_wr !== '0) begin
            wr_events++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                check_output("unexpected_wr", CHKW'(out_wr), CHKW'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check_output("wr_mask", CHKW'(out_wr), CHKW'(mon_e.mask));
                for (int i = 0; i < NQ; i++) begin
                    if (mon_e.mask[i]) begin
                        check_output($sformatf("data_p%0d", i), CHKW'(out_data[i*DW +: DW]), CHKW'(mon_e.data));
                        check_output($sformatf("ctrl_p%0d", i), CHKW'(out_ctrl[i*CW +: CW]), CHKW'(mon_e.ctrl));
                    end
                end
            end
        end
    end

    task automatic build_pkt(input logic [15:0] field, input int n, input bit malformed);
        logic [DW-1:0] hdr;
        pkt_data.delete();
        pkt_ctrl.delete();
        hdr = {$urandom(), $urandom()};
        hdr[16 +: 16] = field;
        pkt_data.push_back(hdr);
        pkt_ctrl.push_back(malformed ? 8'h00 : 8'hFF);
        for (int i = 1; i < n - 1; i++) begin
            pkt_data.push_back({$urandom(), $urandom()});
            pkt_ctrl.push_back(8'h00);
        end
        pkt_data.push_back({$urandom(), $urandom()});
        pkt_ctrl.push_back(8'h0F);
        pkt_mask = malformed ? '0 : field[NQ-1:0];
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int n = 0;
        while (in_rdy !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 300) check_output("in_rdy_timeout", CHKW'(in_rdy), CHKW'(1));
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(posedge clk); #1;
        in_wr   = 1'b0;
    endtask

    task automatic apply_stimulus(input int from, input int to);
        exp_t e;
        for (int i = from; i <= to; i++) begin
            if (pkt_mask != '0) begin
                e.mask = pkt_mask;
                e.data = pkt_data[i];
                e.ctrl = pkt_ctrl[i];
                exp_q.push_back(e);
            end
            send_word(pkt_data[i], pkt_ctrl[i]);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_output(tag, CHKW'(exp_q.size()), CHKW'(0));
    endtask

    task automatic clear_counters();
        wr_events = 0;
        first_wr  = -1;
        last_wr   = -1;
    endtask

    initial begin
        #200000;
        $error("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_data = '0;
        in_ctrl = '0;
        in_wr   = 1'b0;
        out_rdy = '1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_out_wr", CHKW'(out_wr), CHKW'(0));
        check_output("rst_out_data", CHKW'(out_data), CHKW'(0));
        check_output("rst_out_ctrl", CHKW'(out_ctrl), CHKW'(0));
        check_output("rst_pkt_dropped", CHKW'(pkt_dropped), CHKW'(0));
        check_output("rst_in_rdy", CHKW'(in_rdy), CHKW'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] unicast to port 2");
        clear_counters();
        build_pkt(16'h0004, 5, 1'b0);
        apply_stimulus(0, 4);
        wait_drain("drain_unicast");
        check_output("unicast_writes", CHKW'(wr_events), CHKW'(5));
        check_output("unicast_span", CHKW'(last_wr - first_wr + 1), CHKW'(5));

        $display("[TB] back-to-back packets to ports 5 and 6");
        clear_counters();
        build_pkt(16'h0020, 4, 1'b0);
        apply_stimulus(0, 3);
        build_pkt(16'h0040, 3, 1'b0);
        apply_stimulus(0, 2);
        wait_drain("drain_b2b");
        check_output("b2b_writes", CHKW'(wr_events), CHKW'(7));

        $display("[TB] multicast 0x81 with port 7 stalled");
        clear_counters();
        build_pkt(16'h0081, 8, 1'b0);
        apply_stimulus(0, 3);
        out_rdy[7] = 1'b0;
        fork
            apply_stimulus(4, 7);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_rdy[7] = 1'b1;
            end
        join
        wait_drain("drain_mcast");
        check_output("mcast_writes", CHKW'(wr_events), CHKW'(8));

        $display("[TB] zero-destination drop then port 1");
        clear_counters();
        drops_before = drop_count;
        build_pkt(16'h0000, 6, 1'b0);
        apply_stimulus(0, 5);
        repeat (12) @(posedge clk);
        #1;
        check_output("drop_pulses", CHKW'(drop_count - drops_before), CHKW'(1));
        check_output("drop_writes", CHKW'(wr_events), CHKW'(0));
        build_pkt(16'h0002, 4, 1'b0);
        apply_stimulus(0, 3);
        wait_drain("drain_after_drop");
        check_output("after_drop_writes", CHKW'(wr_events), CHKW'(4));

        $display("[TB] malformed packet");
        clear_counters();
        drops_before = drop_count;
        build_pkt(16'h0008, 5, 1'b1);
        apply_stimulus(0, 4);
        repeat (12) @(posedge clk);
        #1;
        check_output("malformed_pulses", CHKW'(drop_count - drops_before), CHKW'(1));
        check_output("malformed_writes", CHKW'(wr_events), CHKW'(0));

        $display("[TB] bitmap bits above the port count");
        clear_counters();
        drops_before = drop_count;
        build_pkt(16'h3C00, 4, 1'b0);
        apply_stimulus(0, 3);
        build_pkt(16'h5510, 4, 1'b0);
        apply_stimulus(0, 3);
        wait_drain("drain_highbits");
        check_output("highbits_pulses", CHKW'(drop_count - drops_before), CHKW'(1));
        check_output("highbits_writes", CHKW'(wr_events), CHKW'(4));

        $display("[TB] backpressure on port 3");
        clear_counters();
        out_rdy[3] = 1'b0;
        build_pkt(16'h0008, 10, 1'b0);
        apply_stimulus(0, 1);
        check_output("bp_in_rdy_2words", CHKW'(in_rdy), CHKW'(1));
        apply_stimulus(2, 2);
        check_output("bp_in_rdy_3words", CHKW'(in_rdy), CHKW'(0));
        fork
            apply_stimulus(3, 9);
            begin
                repeat (6) @(posedge clk);
                #1;
                check_output("bp_in_rdy_held", CHKW'(in_rdy), CHKW'(0));
                check_output("bp_no_writes", CHKW'(wr_events), CHKW'(0));
                out_rdy[3] = 1'b1;
            end
        join
        wait_drain("drain_bp");
        check_output("bp_writes", CHKW'(wr_events), CHKW'(10));

        $display("[TB] reset in the middle of a packet");
        build_pkt(16'h0001, 8, 1'b0);
        apply_stimulus(0, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        check_output("midrst_out_wr", CHKW'(out_wr), CHKW'(0));
        check_output("midrst_in_rdy", CHKW'(in_rdy), CHKW'(1));
        check_output("midrst_pkt_dropped", CHKW'(pkt_dropped), CHKW'(0));
        clear_counters();
        drops_before = drop_count;
        repeat (3) @(posedge clk);
        #1;
        build_pkt(16'h0008, 5, 1'b0);
        apply_stimulus(0, 4);
        wait_drain("drain_after_rst");
        check_output("after_rst_writes", CHKW'(wr_events), CHKW'(5));
        check_output("after_rst_drops", CHKW'(drop_count - drops_before), CHKW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
